reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Two-read, one-write register file with combinational reads and asynchronous clear.
// Entries are plain storage; entry 0 is writable like every other entry.
module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic        [ADDR_W-1:0] RA1,
    input  logic        [ADDR_W-1:0] RA2,
    input  logic        [ADDR_W-1:0] WA,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     clk,
    input  logic                     write_enable,
    output logic signed [DATA_W-1:0] data_out1,
    output logic signed [DATA_W-1:0] data_out2,
    input  logic                     rst_n
);

    localparam int DEPTH = 1 << ADDR_W;

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic signed [DATA_W-1:0] mem_d [DEPTH];

    // Next-state of the array: only the addressed entry changes on a strobed write.
    always_comb begin
        mem_d = mem_q;
        if (write_enable) begin
            mem_d[WA] = data_in;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage update; reset clears every entry regardless of the clock and wins over a coincident write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads come straight from stored state, so a write is visible only after its edge.
    assign data_out1 = mem_q[RA1];
    assign data_out2 = mem_q[RA2];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic against an array model.
module tb_reg_file;

    logic              clk;
    logic              rst_n;
    logic        [3:0] ra1;
    logic        [3:0] ra2;
    logic        [3:0] wa;
    logic signed [7:0] data_in;
    logic              write_enable;
    logic signed [7:0] data_out1;
    logic signed [7:0] data_out2;

    logic signed [7:0] model [16];
    int checks;
    int failures;

    reg_file #(.DATA_W(8), .ADDR_W(4)) dut (
        .RA1(ra1),
        .RA2(ra2),
        .WA(wa),
        .data_in(data_in),
        .clk(clk),
        .write_enable(write_enable),
        .data_out1(data_out1),
        .data_out2(data_out2),
        .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 8'sd0;
    endtask

    initial begin
        logic [3:0] tmp_addr;
        checks = 0;
        failures = 0;
        clear_model();
        rst_n = 1'b0;
        write_enable = 1'b0;
        ra1 = 4'd0;
        ra2 = 4'd0;
        wa = 4'd0;
        data_in = 8'sd0;

        // Power-up reset: every address reads 0 during and after reset.
        #2;
        for (int a = 0; a < 16; a++) begin
            ra1 = a[3:0];
            ra2 = 4'(15 - a);
            #1;
            chk("reset_rd1", data_out1, 8'd0);
            chk("reset_rd2", data_out2, 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            ra1 = a[3:0];
            ra2 = a[3:0];
            #1;
            chk("post_reset_rd1", data_out1, model[a]);
            chk("post_reset_rd2", data_out2, model[a]);
        end

        // Write then read: entry k holds k-6.
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            write_enable = 1'b1;
            wa = k[3:0];
            data_in = 8'(k - 6);
            ra1 = k[3:0];
            @(posedge clk);
            model[k] = 8'(k - 6);
            #1;
            chk("write_read", data_out1, model[k]);
        end
        ra1 = 4'd4;
        #1;
        chk("write_read_k4", data_out1, 8'hFE);
        ra1 = 4'd7;
        #1;
        chk("write_read_k7", data_out1, 8'h01);

        // Write disabled: entries 0..3 stay 0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            write_enable = 1'b0;
            wa = k[3:0];
            data_in = 8'(k - 6);
            @(posedge clk);
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            ra1 = k[3:0];
            #1;
            chk("write_disabled", data_out1, 8'h00);
        end

        // Dual port with wrap-around addressing.
        @(negedge clk);
        write_enable = 1'b1;
        wa = 4'd15;
        data_in = 8'sd9;
        @(posedge clk);
        model[15] = 8'sd9;
        @(negedge clk);
        wa = 4'd5;
        data_in = -8'sd1;
        @(posedge clk);
        model[5] = -8'sd1;
        @(negedge clk);
        write_enable = 1'b0;
        ra1 = 4'd1;
        tmp_addr = ra1 - 4'd2;
        ra2 = tmp_addr;
        #1;
        chk("wrap_rd2", data_out2, 8'd9);
        chk("wrap_rd1", data_out1, model[1]);
        ra1 = 4'd5;
        ra2 = 4'd5;
        #1;
        chk("same_addr_rd1", data_out1, 8'hFF);
        chk("same_addr_rd2", data_out2, 8'hFF);

        // No bypass: old value before the edge, new value after.
        @(negedge clk);
        ra1 = 4'd3;
        wa = 4'd3;
        data_in = 8'sd7;
        write_enable = 1'b1;
        #1;
        chk("no_bypass_before", data_out1, 8'd0);
        @(posedge clk);
        model[3] = 8'sd7;
        #1;
        chk("no_bypass_after", data_out1, 8'd7);

        // Mid-operation reset between edges, with a write held active through it.
        @(negedge clk);
        wa = 4'd6;
        data_in = 8'sd33;
        write_enable = 1'b1;
        ra1 = 4'd4;
        ra2 = 4'd7;
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("mid_reset_rd1", data_out1, 8'd0);
        chk("mid_reset_rd2", data_out2, 8'd0);
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            ra1 = a[3:0];
            ra2 = a[3:0];
            #0.25;
            chk("reset_ignores_we1", data_out1, 8'd0);
            chk("reset_ignores_we2", data_out2, 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        write_enable = 1'b0;

        // Random traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            write_enable = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            data_in = 8'($urandom);
            ra1 = 4'($urandom_range(0, 15));
            ra2 = (n % 7 == 0) ? ra1 : 4'($urandom_range(0, 15));
            #1;
            chk("rand_pre_rd1", data_out1, model[ra1]);
            chk("rand_pre_rd2", data_out2, model[ra2]);
            @(posedge clk);
            if (write_enable) model[wa] = data_in;
            #1;
            chk("rand_post_rd1", data_out1, model[ra1]);
            chk("rand_post_rd2", data_out2, model[ra2]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
